// File: rtl/decoder_pkg.sv
// Shared widths, sequencer state encoding and the code-to-strobe mapping
// for the sequenced 4-to-16 decoder.
package decoder_pkg;

    localparam int unsigned CODE_W = 4;
    localparam int unsigned OUT_W  = 16;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HOLD = 2'd1,
        ST_GAP  = 2'd2
    } state_t;

    function automatic logic [OUT_W-1:0] one_hot(input logic [CODE_W-1:0] code);
        return OUT_W'(1) << code;
    endfunction

endpackage

// File: rtl/seq_decoder4to16_if.sv
// Code-producer side of the decoder: code/valid/ready handshake plus the
// dwell that travels with each loaded code.
interface seq_decoder4to16_if #(
    parameter int unsigned DWELL_W = 8
);
    import decoder_pkg::*;

    logic [CODE_W-1:0]  code_in;
    logic               code_valid;
    logic               code_ready;
    logic [DWELL_W-1:0] dwell;

    modport master (output code_in, output code_valid, output dwell, input code_ready);
    modport slave  (input code_in, input code_valid, input dwell, output code_ready);

endinterface

// File: rtl/seq_decoder4to16_code_fifo.sv
// Synchronous FIFO holding pending codes; not_full is registered so that a
// pop in a full cycle cannot open the input in that same cycle.
module code_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head_c,
    output logic             empty,
    output logic             not_full,
    output logic             empty_nxt_c
);
    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    logic [CNT_W-1:0] count_nxt;
    logic             do_push;
    logic             do_pop;

    assign do_push     = push && not_full;
    assign do_pop      = pop && !empty;
    assign count_nxt   = count + CNT_W'(do_push) - CNT_W'(do_pop);
    assign empty_nxt_c = (count_nxt == '0);
    assign head_c      = mem[rd_ptr];

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            empty    <= 1'b1;
            not_full <= 1'b0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            count    <= count_nxt;
            empty    <= (count_nxt == '0);
            not_full <= (count_nxt != CNT_W'(DEPTH));
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/seq_decoder4to16.sv
// Buffers 4-bit codes and plays each one out as a registered one-hot strobe
// for a programmable dwell, separated by one idle (done) cycle.
module seq_decoder4to16
    import decoder_pkg::*;
#(
    parameter int unsigned DEPTH   = 4,
    parameter int unsigned DWELL_W = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 enable,
    seq_decoder4to16_if.slave    bus,
    output logic [OUT_W-1:0]     decoder_out,
    output logic                 done_pulse,
    output logic                 busy
);
    state_t              state;
    state_t              state_nxt;
    logic [DWELL_W-1:0]  cnt;
    logic [DWELL_W-1:0]  cnt_nxt;
    logic [DWELL_W-1:0]  load_cnt;
    logic [CODE_W-1:0]   code_q;
    logic [CODE_W-1:0]   code_nxt;
    logic [CODE_W-1:0]   head;
    logic [OUT_W-1:0]    out_nxt;
    logic                done_nxt;
    logic                busy_nxt;
    logic                pop;
    logic                empty;
    logic                empty_nxt;
    logic                ready;

    code_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (CODE_W)
    ) u_fifo (
        .clk         (clk),
        .rst_n       (rst_n),
        .push        (bus.code_valid),
        .push_data   (bus.code_in),
        .pop         (pop),
        .head_c      (head),
        .empty       (empty),
        .not_full    (ready),
        .empty_nxt_c (empty_nxt)
    );

    assign bus.code_ready = ready;
    assign load_cnt       = (bus.dwell == '0) ? DWELL_W'(1) : bus.dwell;

    // Outputs trail the state by one register stage, giving the two-cycle load latency.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        code_nxt  = code_q;
        pop       = 1'b0;
        out_nxt   = '0;
        done_nxt  = 1'b0;
        case (state)
            ST_IDLE: begin
                if (!empty) begin
                    pop       = 1'b1;
                    code_nxt  = head;
                    cnt_nxt   = load_cnt;
                    state_nxt = ST_HOLD;
                end
            end
            ST_HOLD: begin
                out_nxt = one_hot(code_q);
                if (cnt == DWELL_W'(1)) state_nxt = ST_GAP;
                else                    cnt_nxt   = cnt - DWELL_W'(1);
            end
            ST_GAP: begin
                done_nxt = 1'b1;
                if (!empty) begin
                    pop       = 1'b1;
                    code_nxt  = head;
                    cnt_nxt   = load_cnt;
                    state_nxt = ST_HOLD;
                end else begin
                    state_nxt = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
        // Disabling abandons any in-flight strobe silently; the FIFO is left intact.
        if (!enable) begin
            state_nxt = ST_IDLE;
            pop       = 1'b0;
            out_nxt   = '0;
            done_nxt  = 1'b0;
        end
        busy_nxt = !empty_nxt || (state_nxt != ST_IDLE);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= ST_IDLE;
            cnt         <= '0;
            code_q      <= '0;
            decoder_out <= '0;
            done_pulse  <= 1'b0;
            busy        <= 1'b0;
        end else begin
            state       <= state_nxt;
            cnt         <= cnt_nxt;
            code_q      <= code_nxt;
            decoder_out <= out_nxt;
            done_pulse  <= done_nxt;
            busy        <= busy_nxt;
        end
    end

endmodule

// File: tb/tb_seq_decoder4to16.sv
// Directed bench for seq_decoder4to16 with a queue-based reference model
// compared on every cycle, plus hand-computed spot values.
module tb_seq_decoder4to16;
    import decoder_pkg::*;

    localparam int unsigned DEPTH   = 4;
    localparam int unsigned DWELL_W = 8;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        enable;
    logic [15:0] decoder_out;
    logic        done_pulse;
    logic        busy;

    seq_decoder4to16_if #(.DWELL_W(DWELL_W)) bus ();

    seq_decoder4to16 #(
        .DEPTH   (DEPTH),
        .DWELL_W (DWELL_W)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .enable      (enable),
        .bus         (bus),
        .decoder_out (decoder_out),
        .done_pulse  (done_pulse),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %04h expected %04h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: a code queue plus "which code is strobing, how many cycles left, in gap".
    int          mq[$];
    logic        m_ready = 1'b0;
    logic        m_act   = 1'b0;
    logic        m_gap   = 1'b0;
    int          m_code  = 0;
    int          m_rem   = 0;
    logic [15:0] e_out   = 16'h0;
    logic        e_done  = 1'b0;
    logic        e_busy  = 1'b0;
    logic        model_live = 1'b0;

    always @(posedge clk) begin : model
        logic push;
        if (!rst_n) begin
            mq.delete();
            m_ready = 1'b0;
            m_act   = 1'b0;
            m_gap   = 1'b0;
            e_out   = 16'h0;
            e_done  = 1'b0;
            e_busy  = 1'b0;
        end else begin
            push   = bus.code_valid && m_ready;
            e_out  = (enable && m_act && !m_gap) ? 16'(16'h1 << m_code) : 16'h0;
            e_done = enable && m_gap;
            if (!enable) begin
                m_act = 1'b0;
                m_gap = 1'b0;
            end else if (!m_act || m_gap) begin
                m_gap = 1'b0;
                if (mq.size() > 0) begin
                    m_code = mq.pop_front();
                    m_rem  = (bus.dwell == '0) ? 1 : int'(bus.dwell);
                    m_act  = 1'b1;
                end else begin
                    m_act = 1'b0;
                end
            end else if (m_rem == 1) begin
                m_gap = 1'b1;
            end else begin
                m_rem = m_rem - 1;
            end
            if (push) mq.push_back(int'(bus.code_in));
            m_ready = (mq.size() < DEPTH);
            e_busy  = (mq.size() > 0) || m_act;
        end
        model_live = 1'b1;
    end

    always @(negedge clk) begin
        if (model_live) begin
            check("out", decoder_out, e_out);
            check("done", 16'(done_pulse), 16'(e_done));
            check("busy", 16'(busy), 16'(e_busy));
            check("ready", 16'(bus.code_ready), 16'(m_ready));
            check("onehot", 16'($countones(decoder_out) <= 1), 16'h1);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int          accept_at;
        logic [15:0] seq_got [12];
        logic [15:0] seq_exp [12];
        int          codes3 [4];
        int          codes6 [4];
        seq_exp = '{16'h0000, 16'h0001, 16'h0000, 16'h0002, 16'h0000, 16'h0004,
                    16'h0000, 16'h8000, 16'h0000, 16'h0080, 16'h0000, 16'h0000};
        codes3  = '{0, 1, 2, 15};
        codes6  = '{1, 2, 3, 4};

        rst_n          = 1'b0;
        enable         = 1'b0;
        bus.code_in    = '0;
        bus.code_valid = 1'b0;
        bus.dwell      = '0;

        // 1: reset
        repeat (2) step();
        check("rst_out", decoder_out, 16'h0);
        check("rst_ready", 16'(bus.code_ready), 16'h0);
        check("rst_busy", 16'(busy), 16'h0);
        rst_n = 1'b1;
        step();
        check("rel_ready", 16'(bus.code_ready), 16'h1);

        // 2: single code A, dwell 3 (dwell changed mid-strobe must not matter)
        enable         = 1'b1;
        bus.dwell      = 8'd3;
        bus.code_in    = 4'hA;
        bus.code_valid = 1'b1;
        step();
        bus.code_valid = 1'b0;
        check("a_t0", decoder_out, 16'h0);
        step();
        check("a_t1", decoder_out, 16'h0);
        step();
        check("a_t2", decoder_out, 16'h0400);
        bus.dwell = 8'd7;
        step();
        check("a_t3", decoder_out, 16'h0400);
        step();
        check("a_t4", decoder_out, 16'h0400);
        step();
        check("a_t5_out", decoder_out, 16'h0);
        check("a_t5_done", 16'(done_pulse), 16'h1);
        step();
        check("a_t6_done", 16'(done_pulse), 16'h0);
        check("a_t6_busy", 16'(busy), 16'h0);

        // 3: fill while disabled, stall a fifth code, then drain with dwell 1
        enable    = 1'b0;
        bus.dwell = 8'd1;
        for (int i = 0; i < 4; i++) begin
            bus.code_in    = 4'(codes3[i]);
            bus.code_valid = 1'b1;
            step();
        end
        check("fill_ready", 16'(bus.code_ready), 16'h0);
        bus.code_in = 4'h7;
        step();
        check("stall_ready", 16'(bus.code_ready), 16'h0);
        check("stall_out", decoder_out, 16'h0);
        enable    = 1'b1;
        accept_at = -1;
        for (int k = 0; k < 12; k++) begin
            if (bus.code_valid && bus.code_ready && accept_at < 0) accept_at = k + 1;
            step();
            if (accept_at > 0) bus.code_valid = 1'b0;
            seq_got[k] = decoder_out;
        end
        bus.code_valid = 1'b0;
        check("accept7_step", 16'(accept_at), 16'd2);
        for (int k = 0; k < 12; k++) check($sformatf("drain_%0d", k), seq_got[k], seq_exp[k]);

        // 4: dwell 0 behaves as dwell 1
        bus.dwell      = 8'd0;
        bus.code_in    = 4'h5;
        bus.code_valid = 1'b1;
        step();
        bus.code_valid = 1'b0;
        step();
        check("d0_t1", decoder_out, 16'h0);
        step();
        check("d0_t2", decoder_out, 16'h0020);
        step();
        check("d0_t3_out", decoder_out, 16'h0);
        check("d0_t3_done", 16'(done_pulse), 16'h1);
        step();

        // 5: abort a long strobe with enable, queued 9 survives
        bus.dwell      = 8'd10;
        bus.code_in    = 4'h3;
        bus.code_valid = 1'b1;
        step();
        bus.code_in = 4'h9;
        step();
        bus.code_valid = 1'b0;
        repeat (4) step();
        check("ab_4th", decoder_out, 16'h0008);
        enable = 1'b0;
        step();
        check("ab_out", decoder_out, 16'h0);
        check("ab_done", 16'(done_pulse), 16'h0);
        repeat (3) step();
        check("ab_idle_out", decoder_out, 16'h0);
        check("ab_busy", 16'(busy), 16'h1);
        bus.dwell = 8'd2;
        enable    = 1'b1;
        step();
        check("re_t1", decoder_out, 16'h0);
        step();
        check("re_t2", decoder_out, 16'h0200);
        step();
        check("re_t3", decoder_out, 16'h0200);
        step();
        check("re_done", 16'(done_pulse), 16'h1);
        step();

        // 6: reset during a strobe with three codes queued
        bus.dwell = 8'd5;
        for (int i = 0; i < 4; i++) begin
            bus.code_in    = 4'(codes6[i]);
            bus.code_valid = 1'b1;
            step();
        end
        bus.code_valid = 1'b0;
        check("r6_pre", decoder_out, 16'h0002);
        rst_n = 1'b0;
        step();
        check("r6_out", decoder_out, 16'h0);
        check("r6_busy", 16'(busy), 16'h0);
        check("r6_ready", 16'(bus.code_ready), 16'h0);
        rst_n = 1'b1;
        step();
        check("r6_rel_ready", 16'(bus.code_ready), 16'h1);
        for (int k = 0; k < 10; k++) begin
            step();
            check($sformatf("r6_quiet_%0d", k), decoder_out, 16'h0);
        end

        step();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
